inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter INST_BITS, default 32: width of an instruction word.
REQ-002 Parameter ADDR_BITS, default 16: width of the word-addressed PC.
REQ-003 Parameter RESET_PC, default 0: PC loaded at reset.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: asynchronous, active-low reset (asserted when 0).
REQ-006 Port o_imem_req  output  1: one-cycle pulse requesting the instruction at o_imem_addr.
REQ-007 Port o_imem_addr  output  ADDR_BITS: word address of the request; valid only while o_imem_req=1.
REQ-008 Port i_imem_rdata  input  INST_BITS: returned instruction word.
REQ-009 Port i_imem_rvalid  input  1: i_imem_rdata valid; returned after 1 or more cycles, at most one request outstanding.
REQ-010 Port o_inst  output  INST_BITS: instruction presented to the decoder.
REQ-011 Port o_inst_valid  output  1: o_inst is valid; drives the decoder's instruction-valid input.
REQ-012 Port o_inst_pc  output  ADDR_BITS: word address of o_inst.
REQ-013 Port i_stall  input  1: downstream cannot accept; hold o_inst/o_inst_valid/o_inst_pc.
REQ-014 Ports i_j_addr/i_j_addr_valid, i_jal_addr/i_jal_addr_valid  input  ADDR_BITS/1: jump targets from the decoder.
REQ-015 Ports i_jr_addr/i_jr_valid  input  ADDR_BITS/1: register-jump target from the later stage.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT, OUT.
REQ-017 IDLE: entered on reset; on the next edge after rst deasserts, go to REQ.
REQ-018 REQ: assert o_imem_req with o_imem_addr=pc; go to WAIT.
REQ-019 WAIT: on i_imem_rvalid with drop=0, register o_inst=rdata, o_inst_pc=pc, o_inst_valid=1, pc<=pc+1, go to OUT; otherwise stay.
REQ-020 OUT with i_stall=1: hold all outputs and stay; no memory request.
REQ-021 OUT with i_stall=0: assert o_imem_req for pc in the same cycle, clear o_inst_valid next edge, go to WAIT. Steady-state throughput is 1 instruction per 2 cycles with 1-cycle memory.
REQ-022 Redirect priority: jr > jal > j. Any redirect overrides i_stall.
REQ-023 On a redirect, pc<=target[ADDR_BITS-1:0], o_inst_valid<=0 next edge, and the next state depends on the current state:
- IDLE: go to REQ.
- REQ: request still issues with the old address; set drop; go to WAIT.
- WAIT without rvalid: set drop; stay in WAIT.
- WAIT with rvalid in the same cycle: discard the data; go to REQ.
- OUT: go to REQ.
REQ-024 In WAIT, an i_imem_rvalid with drop=1 SHALL be discarded, clear drop, and go to REQ with no o_inst_valid pulse.
REQ-025 i_imem_rvalid outside WAIT SHALL be ignored.
REQ-026 PC increment SHALL wrap modulo 2^ADDR_BITS (all-ones + 1 = 0).
REQ-027 At most one memory request SHALL be outstanding at any time.

Reset
REQ-028 While rst=0, immediately and regardless of clk, the block SHALL force:
- state=IDLE, pc=RESET_PC, drop=0.
- o_imem_req=0, o_imem_addr=0.
- o_inst=0, o_inst_valid=0, o_inst_pc=0.
REQ-029 Reset asserted mid-request SHALL abandon the request; any rvalid that arrives after reset is released and before the next REQ SHALL be ignored.

Structure
REQ-030 INST_BITS, ADDR_BITS, and the FSM state encodings SHALL live in the shared define file used by the decoder.
REQ-031 No sub-module; a single flat module containing the FSM, the PC register and the output register.

Verification
REQ-032 Reset release, 1-cycle memory returning 32'h00221800 at word 0: o_imem_req with addr 0 two edges after release; o_inst_valid=1 with o_inst=32'h00221800, o_inst_pc=0.
REQ-033 i_stall=1 for 5 cycles while in OUT: o_inst held, no o_imem_req; after stall drops, request issued for addr 1.
REQ-034 i_j_addr_valid=1 with target 4 while WAIT is outstanding on addr 1: the response for addr 1 is discarded (no valid pulse); next request goes to addr 4.
REQ-035 Same-cycle i_jr_valid (target 8), i_jal_addr_valid (target 5) and i_j_addr_valid (target 4): next request goes to addr 8.
REQ-036 pc=16'hFFFF fetched: o_inst_pc=16'hFFFF, next request goes to addr 0.
REQ-037 rst=0 pulse while in WAIT, with rvalid arriving 1 cycle after release: no o_inst_valid; first request goes to RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared instruction/address widths and fetch FSM encoding
package inst_fetch_pkg;

  localparam int unsigned IF_INST_BITS = 32;
  localparam int unsigned IF_ADDR_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-outstanding instruction fetch with jump redirect
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned          INST_BITS = IF_INST_BITS,
  parameter int unsigned          ADDR_BITS = IF_ADDR_BITS,
  parameter logic [ADDR_BITS-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 o_imem_req,
  output logic [ADDR_BITS-1:0] o_imem_addr,
  input  logic [INST_BITS-1:0] i_imem_rdata,
  input  logic                 i_imem_rvalid,
  output logic [INST_BITS-1:0] o_inst,
  output logic                 o_inst_valid,
  output logic [ADDR_BITS-1:0] o_inst_pc,
  input  logic                 i_stall,
  input  logic [ADDR_BITS-1:0] i_j_addr,
  input  logic                 i_j_addr_valid,
  input  logic [ADDR_BITS-1:0] i_jal_addr,
  input  logic                 i_jal_addr_valid,
  input  logic [ADDR_BITS-1:0] i_jr_addr,
  input  logic                 i_jr_valid
);

  fetch_state_e         state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d;
  logic                 drop_q, drop_d;
  logic [INST_BITS-1:0] inst_q, inst_d;
  logic                 inst_valid_q, inst_valid_d;
  logic [ADDR_BITS-1:0] inst_pc_q, inst_pc_d;

  logic                 redir;
  logic [ADDR_BITS-1:0] redir_addr;
  logic                 req;

  // Redirect select: the later-stage register jump wins over decoder jumps.
  always_comb begin
    redir = i_jr_valid | i_jal_addr_valid | i_j_addr_valid;
    if (i_jr_valid) begin
      redir_addr = i_jr_addr;
    end else if (i_jal_addr_valid) begin
      redir_addr = i_jal_addr;
    end else begin
      redir_addr = i_j_addr;
    end
  end

  // Next-state logic; a redirect always withdraws the presented instruction.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    inst_pc_d    = inst_pc_q;
    req          = 1'b0;

    if (redir) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redir) begin
          pc_d = redir_addr;
        end
      end

      ST_REQ: begin
        // The request goes out with the old PC even when redirected; its data is dropped later.
        req     = 1'b1;
        state_d = ST_WAIT;
        if (redir) begin
          pc_d   = redir_addr;
          drop_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (i_imem_rvalid) begin
          if (redir || drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
            if (redir) begin
              pc_d = redir_addr;
            end
          end else begin
            inst_d       = i_imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + ADDR_BITS'(1);
            state_d      = ST_OUT;
          end
        end else if (redir) begin
          pc_d   = redir_addr;
          drop_d = 1'b1;
        end
      end

      ST_OUT: begin
        if (redir) begin
          pc_d    = redir_addr;
          state_d = ST_REQ;
        end else if (!i_stall) begin
          // Hand-off cycle: issue the next fetch while the decoder takes this one.
          req          = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = ST_WAIT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, PC and presented-instruction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign o_imem_req   = req;
  assign o_imem_addr  = req ? pc_q : '0;
  assign o_inst       = inst_q;
  assign o_inst_valid = inst_valid_q;
  assign o_inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch against a transaction-level model
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        o_imem_req;
  logic [15:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic        i_imem_rvalid;
  logic [31:0] o_inst;
  logic        o_inst_valid;
  logic [15:0] o_inst_pc;
  logic        i_stall;
  logic [15:0] i_j_addr;
  logic        i_j_addr_valid;
  logic [15:0] i_jal_addr;
  logic        i_jal_addr_valid;
  logic [15:0] i_jr_addr;
  logic        i_jr_valid;

  inst_fetch #(
    .INST_BITS(32),
    .ADDR_BITS(16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .o_imem_req      (o_imem_req),
    .o_imem_addr     (o_imem_addr),
    .i_imem_rdata    (i_imem_rdata),
    .i_imem_rvalid   (i_imem_rvalid),
    .o_inst          (o_inst),
    .o_inst_valid    (o_inst_valid),
    .o_inst_pc       (o_inst_pc),
    .i_stall         (i_stall),
    .i_j_addr        (i_j_addr),
    .i_j_addr_valid  (i_j_addr_valid),
    .i_jal_addr      (i_jal_addr),
    .i_jal_addr_valid(i_jal_addr_valid),
    .i_jr_addr       (i_jr_addr),
    .i_jr_valid      (i_jr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // stimulus requests for the coming cycle
  logic        drv_stall;
  logic        drv_j, drv_jal, drv_jr;
  logic [15:0] drv_j_addr, drv_jal_addr, drv_jr_addr;

  // memory responder
  bit          mem_pend;
  logic [15:0] mem_addr;
  int          mem_cnt;
  int          fixed_lat;
  int          stray_cycles;
  bit          rand_stray;

  // transaction-level model of what the fetcher owes the decoder and the memory
  bit          m_held;
  logic [31:0] m_inst;
  logic [15:0] m_pc;
  bit          m_pend;
  bit          m_stale;
  logic [15:0] m_pend_addr;
  logic [15:0] m_next;
  bit          m_req_due;

  logic        last_req;
  logic [15:0] last_addr;
  int          vcount;
  int          req_count;

  function automatic logic [31:0] word(input logic [15:0] a);
    if (a == 16'h0000) return 32'h00221800;
    return {a, ~a} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_held    = 0;
    m_pend    = 0;
    m_stale   = 0;
    m_req_due = 0;
    m_next    = 16'h0000;
    mem_pend  = 0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check request, advance model.
  task automatic cycle();
    logic        redir, exp_req, resp, rv_resp, rv_stray;
    logic        old_pend, old_held, old_due, nd;
    logic [15:0] tgt;
    int          lat;

    chk("inst_valid", o_inst_valid, m_held);
    if (m_held) begin
      chk("inst", o_inst, m_inst);
      chk("inst_pc", o_inst_pc, m_pc);
    end
    if (o_inst_valid === 1'b1) vcount++;

    i_stall          = drv_stall;
    i_j_addr_valid   = drv_j;
    i_j_addr         = drv_j_addr;
    i_jal_addr_valid = drv_jal;
    i_jal_addr       = drv_jal_addr;
    i_jr_valid       = drv_jr;
    i_jr_addr        = drv_jr_addr;
    rv_resp  = mem_pend && (mem_cnt == 1);
    rv_stray = !mem_pend && ((stray_cycles > 0) || (rand_stray && $urandom_range(0, 9) == 0));
    i_imem_rvalid = rv_resp || rv_stray;
    i_imem_rdata  = rv_resp ? word(mem_addr) : $urandom();

    #1;
    last_req  = o_imem_req;
    last_addr = o_imem_addr;
    if (o_imem_req === 1'b1) req_count++;

    redir = drv_jr | drv_jal | drv_j;
    tgt   = drv_jr ? drv_jr_addr : (drv_jal ? drv_jal_addr : drv_j_addr);

    exp_req = m_req_due || (m_held && !drv_stall && !redir);
    chk("imem_req", o_imem_req, exp_req);
    if (exp_req) chk("imem_addr", o_imem_addr, m_next);

    old_pend = m_pend;
    old_held = m_held;
    old_due  = m_req_due;
    resp     = old_pend && i_imem_rvalid;
    nd       = 0;
    if (!old_due && !old_held && !old_pend) nd = 1;
    if (old_held && (!drv_stall || redir)) begin
      m_held = 0;
      if (redir) nd = 1;
    end
    if (resp) begin
      m_pend = 0;
      if (m_stale || redir) begin
        nd = 1;
      end else begin
        m_held = 1;
        m_inst = word(m_pend_addr);
        m_pc   = m_pend_addr;
        m_next = m_pend_addr + 16'd1;
      end
    end else if (old_pend && redir) begin
      m_stale = 1;
    end
    if (exp_req) begin
      m_pend      = 1;
      m_pend_addr = m_next;
      m_stale     = redir;
    end
    if (redir) m_next = tgt;
    m_req_due = nd;

    if (rv_resp) mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (o_imem_req === 1'b1) begin
      lat      = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 3);
      mem_pend = 1;
      mem_addr = o_imem_addr;
      mem_cnt  = lat;
    end
    if (stray_cycles > 0) stray_cycles--;

    drv_j   = 0;
    drv_jal = 0;
    drv_jr  = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst           = 1'b0;
    i_imem_rvalid = 1'b0;
    #1;
    chk("rst_imem_req", o_imem_req, 0);
    chk("rst_imem_addr", o_imem_addr, 0);
    chk("rst_inst", o_inst, 0);
    chk("rst_inst_valid", o_inst_valid, 0);
    chk("rst_inst_pc", o_inst_pc, 0);
    repeat (n) @(posedge clk);
    #1;
    chk("rst_hold_req", o_imem_req, 0);
    chk("rst_hold_valid", o_inst_valid, 0);
    model_reset();
    rst = 1'b1;
  endtask

  task automatic run_until_valid(input string tag, input int limit);
    int k = 0;
    while (o_inst_valid !== 1'b1 && k < limit) begin
      cycle();
      k++;
    end
    chk(tag, o_inst_valid, 1);
  endtask

  task automatic run_until_req(input string tag, input int limit, input logic [15:0] addr);
    int k = 0;
    last_req = 1'b0;
    while (last_req !== 1'b1 && k < limit) begin
      cycle();
      k++;
    end
    chk({tag, "_seen"}, last_req, 1);
    chk({tag, "_addr"}, last_addr, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rq0, vc0;
    rst = 1'b0;
    i_imem_rdata = '0; i_imem_rvalid = 1'b0; i_stall = 1'b0;
    i_j_addr = '0; i_j_addr_valid = 1'b0;
    i_jal_addr = '0; i_jal_addr_valid = 1'b0;
    i_jr_addr = '0; i_jr_valid = 1'b0;
    drv_stall = 0; drv_j = 0; drv_jal = 0; drv_jr = 0;
    drv_j_addr = '0; drv_jal_addr = '0; drv_jr_addr = '0;
    fixed_lat = 1; stray_cycles = 0; rand_stray = 0;
    vcount = 0; req_count = 0;
    model_reset();
    @(posedge clk);
    #1;

    // reset release and first fetch from word 0
    apply_reset(3);
    drv_stall = 1;
    cycle();
    chk("first_idle_no_req", last_req, 0);
    cycle();
    chk("first_req", last_req, 1);
    chk("first_req_addr", last_addr, 16'h0000);
    cycle();
    chk("first_valid", o_inst_valid, 1);
    chk("first_inst", o_inst, 32'h00221800);
    chk("first_inst_pc", o_inst_pc, 16'h0000);

    // five stalled cycles hold the instruction and issue nothing
    rq0 = req_count;
    repeat (5) cycle();
    chk("stall_no_req", req_count - rq0, 0);
    chk("stall_hold_inst", o_inst, 32'h00221800);
    drv_stall = 0;
    fixed_lat = 2;
    cycle();
    chk("post_stall_req", last_req, 1);
    chk("post_stall_addr", last_addr, 16'h0001);

    // jump while the fetch of word 1 is outstanding
    vc0 = vcount;
    drv_j = 1; drv_j_addr = 16'h0004;
    cycle();
    cycle();
    run_until_req("jump_req", 6, 16'h0004);
    chk("jump_no_valid_pulse", vcount - vc0, 0);

    // simultaneous redirects: register jump wins
    fixed_lat = 1;
    run_until_valid("wait_valid_4", 10);
    chk("inst_pc_4", o_inst_pc, 16'h0004);
    drv_jr = 1; drv_jr_addr = 16'h0008;
    drv_jal = 1; drv_jal_addr = 16'h0005;
    drv_j = 1; drv_j_addr = 16'h0004;
    cycle();
    run_until_req("prio_req", 6, 16'h0008);

    // PC wrap at the top of the address space
    run_until_valid("wait_valid_8", 10);
    drv_j = 1; drv_j_addr = 16'hFFFF;
    cycle();
    run_until_req("wrap_req", 6, 16'hFFFF);
    run_until_valid("wait_valid_ffff", 10);
    chk("wrap_inst_pc", o_inst_pc, 16'hFFFF);
    chk("wrap_inst", o_inst, word(16'hFFFF));
    fixed_lat = 3;
    cycle();
    chk("wrap_next_req", last_req, 1);
    chk("wrap_next_addr", last_addr, 16'h0000);

    // reset while a fetch is outstanding, stray response after release
    run_until_valid("wait_valid_0", 10);
    cycle();
    chk("pre_rst_req", last_req, 1);
    vc0 = vcount;
    apply_reset(1);
    stray_cycles = 2;
    cycle();
    chk("rst_idle_no_req", last_req, 0);
    cycle();
    chk("rst_first_req", last_req, 1);
    chk("rst_first_addr", last_addr, 16'h0000);
    chk("rst_no_valid", vcount - vc0, 0);

    // randomized traffic against the model
    fixed_lat  = 0;
    rand_stray = 1;
    for (int i = 0; i < 600; i++) begin
      drv_stall = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 99) < 6) begin
        drv_j = 1; drv_j_addr = 16'($urandom());
      end
      if ($urandom_range(0, 99) < 5) begin
        drv_jal = 1; drv_jal_addr = ($urandom_range(0, 1) == 1) ? 16'hFFFE : 16'($urandom());
      end
      if ($urandom_range(0, 99) < 4) begin
        drv_jr = 1; drv_jr_addr = 16'($urandom());
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
